// File: rtl/tag_lookup_issue_if.sv
// Bus bundle for the tag lookup issue stage: host AR/AW requests, DRAM AR channel,
// tag FIFO push side and the comparator retire pulse.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

interface tag_lookup_issue_if #(
  parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int ID_WIDTH   = `AXI_ID_WIDTH
);
  logic [ID_WIDTH-1:0]           s_arid_i;
  logic [ADDR_WIDTH-1:0]         s_araddr_i;
  logic                          s_arvalid_i;
  logic                          s_arready_o;
  logic [ID_WIDTH-1:0]           s_awid_i;
  logic [ADDR_WIDTH-1:0]         s_awaddr_i;
  logic                          s_awvalid_i;
  logic                          s_awready_o;
  logic [ID_WIDTH-1:0]           m_arid_o;
  logic [ADDR_WIDTH-1:0]         m_araddr_o;
  logic [7:0]                    m_arlen_o;
  logic                          m_arvalid_o;
  logic                          m_arready_i;
  logic                          tag_fifo_afull_i;
  logic                          tag_fifo_wren_o;
  logic [ADDR_WIDTH+ID_WIDTH:0]  tag_fifo_data_o;
  logic                          lookup_done_i;

  // The lookup stage itself
  modport slave (
    input  s_arid_i, s_araddr_i, s_arvalid_i,
    output s_arready_o,
    input  s_awid_i, s_awaddr_i, s_awvalid_i,
    output s_awready_o,
    output m_arid_o, m_araddr_o, m_arlen_o, m_arvalid_o,
    input  m_arready_i,
    input  tag_fifo_afull_i,
    output tag_fifo_wren_o, tag_fifo_data_o,
    input  lookup_done_i
  );

  // The surrounding host / DRAM / FIFO environment
  modport master (
    output s_arid_i, s_araddr_i, s_arvalid_i,
    input  s_arready_o,
    output s_awid_i, s_awaddr_i, s_awvalid_i,
    input  s_awready_o,
    input  m_arid_o, m_araddr_o, m_arlen_o, m_arvalid_o,
    output m_arready_i,
    output tag_fifo_afull_i,
    input  tag_fifo_wren_o, tag_fifo_data_o,
    output lookup_done_i
  );
endinterface

// File: rtl/tag_lookup_issue.sv
// DRAM-cache front end: arbitrates host AR/AW requests, issues one DRAM read burst per
// request for the indexed set, and pushes the request descriptor to the tag FIFO.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 16
`endif
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 6
`endif

module tag_lookup_issue #(
  parameter int ADDR_WIDTH      = `AXI_ADDR_WIDTH,
  parameter int ID_WIDTH        = `AXI_ID_WIDTH,
  parameter int INDEX_WIDTH     = `INDEX_WIDTH,
  parameter int OFFSET_WIDTH    = `OFFSET_WIDTH,
  parameter int BURST_LEN       = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  tag_lookup_issue_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] SET_MASK =
    ((ONE << (INDEX_WIDTH + OFFSET_WIDTH)) - ONE) & ~((ONE << OFFSET_WIDTH) - ONE);
  localparam logic [7:0] ARLEN = 8'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  cap_is_write;
  logic [ID_WIDTH-1:0]   cap_id;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [CNT_W-1:0]      outstanding;
  logic                  rr_prio;
  logic                  can_accept;
  logic                  grant_read;
  logic                  grant_write;
  logic                  issue_hs;
  logic                  retire;

  // rst_n is folded in so the host readys drop the instant reset asserts
  assign can_accept = rst_n && !bus.tag_fifo_afull_i && (outstanding < CNT_MAX);
  assign retire     = bus.lookup_done_i && (outstanding != '0);

  always_comb begin
    state_next          = state;
    grant_read          = 1'b0;
    grant_write         = 1'b0;
    issue_hs            = 1'b0;
    bus.s_arready_o     = 1'b0;
    bus.s_awready_o     = 1'b0;
    bus.m_arvalid_o     = 1'b0;
    bus.m_arid_o        = '0;
    bus.m_araddr_o      = '0;
    bus.m_arlen_o       = '0;
    bus.tag_fifo_wren_o = 1'b0;
    bus.tag_fifo_data_o = '0;
    case (state)
      S_IDLE: begin
        if (can_accept) begin
          // rr_prio == 0 favours reads when both sides are requesting
          if (bus.s_arvalid_i && (!bus.s_awvalid_i || !rr_prio)) begin
            grant_read = 1'b1;
          end else if (bus.s_awvalid_i) begin
            grant_write = 1'b1;
          end
        end
        bus.s_arready_o = grant_read;
        bus.s_awready_o = grant_write;
        if (grant_read || grant_write) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.m_arvalid_o = 1'b1;
        bus.m_arid_o    = cap_id;
        bus.m_araddr_o  = cap_addr & SET_MASK;
        bus.m_arlen_o   = ARLEN;
        if (bus.m_arready_i) begin
          issue_hs            = 1'b1;
          bus.tag_fifo_wren_o = 1'b1;
          bus.tag_fifo_data_o = {cap_is_write, cap_id, cap_addr};
          state_next          = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_is_write <= 1'b0;
      cap_id       <= '0;
      cap_addr     <= '0;
      rr_prio      <= 1'b0;
    end else if (grant_read) begin
      cap_is_write <= 1'b0;
      cap_id       <= bus.s_arid_i;
      cap_addr     <= bus.s_araddr_i;
      rr_prio      <= 1'b1;
    end else if (grant_write) begin
      cap_is_write <= 1'b1;
      cap_id       <= bus.s_awid_i;
      cap_addr     <= bus.s_awaddr_i;
      rr_prio      <= 1'b0;
    end
  end

  // Simultaneous issue and retire leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (issue_hs && !retire) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (retire && !issue_hs) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

endmodule
